// File: rtl/ec11b_pkg.sv
// rtl/ec11b_pkg.sv - shared constants and long-press state encoding for the EC11B pin filter
package ec11b_pkg;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned AB_DEB_CYC_DEF = CLK_HZ / 1000;
  localparam int unsigned D_DEB_CYC_DEF  = CLK_HZ / 100;
  localparam int unsigned LONG_CYC_DEF   = CLK_HZ;

  typedef enum logic [1:0] {
    LP_IDLE  = 2'd0,
    LP_HELD  = 2'd1,
    LP_FIRED = 2'd2
  } lp_state_t;

endpackage

// File: rtl/ec11b_deb_ch.sv
// rtl/ec11b_deb_ch.sv - one pin: two-flop synchroniser, debounce counter, level and edge pulses
module ec11b_deb_ch #(
  parameter int unsigned DEB_CYC = 8,
  parameter logic        RST_LVL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CW      = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1      <= RST_LVL;
      s2      <= RST_LVL;
      level_o <= RST_LVL;
      cnt     <= '0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      s1     <= pin_i;
      s2     <= s1;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      // Any cycle of agreement restarts the stability window.
      if (s2 == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level_o <= s2;
        cnt     <= '0;
        rise_o  <= s2;
        fall_o  <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ec11b_pin_filter.sv
// rtl/ec11b_pin_filter.sv - debounces EC11B A/B/D pins and detects a long key press
module ec11b_pin_filter
  import ec11b_pkg::*;
#(
  parameter int unsigned AB_DEB_CYC = AB_DEB_CYC_DEF,
  parameter int unsigned D_DEB_CYC  = D_DEB_CYC_DEF,
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter logic        RST_LVL    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_pin_i,
  input  logic b_pin_i,
  input  logic d_pin_i,
  output logic a_o,
  output logic b_o,
  output logic d_o,
  output logic a_rise_o,
  output logic a_fall_o,
  output logic b_rise_o,
  output logic b_fall_o,
  output logic d_press_o,
  output logic d_release_o,
  output logic d_long_o
);

  localparam int unsigned   LW       = $clog2(LONG_CYC);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYC - 1);

  logic d_rise;
  logic d_fall;

  ec11b_deb_ch #(.DEB_CYC(AB_DEB_CYC), .RST_LVL(RST_LVL)) u_deb_a (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(a_pin_i),
    .level_o(a_o), .rise_o(a_rise_o), .fall_o(a_fall_o)
  );

  ec11b_deb_ch #(.DEB_CYC(AB_DEB_CYC), .RST_LVL(RST_LVL)) u_deb_b (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(b_pin_i),
    .level_o(b_o), .rise_o(b_rise_o), .fall_o(b_fall_o)
  );

  ec11b_deb_ch #(.DEB_CYC(D_DEB_CYC), .RST_LVL(RST_LVL)) u_deb_d (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(d_pin_i),
    .level_o(d_o), .rise_o(d_rise), .fall_o(d_fall)
  );

  // Pressed means leaving the idle level, whichever polarity that is.
  assign d_press_o   = RST_LVL ? d_fall : d_rise;
  assign d_release_o = RST_LVL ? d_rise : d_fall;

  lp_state_t     state_q;
  lp_state_t     state_d;
  logic [LW-1:0] long_cnt_q;
  logic          long_fire;
  logic          cnt_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= LP_IDLE;
      long_cnt_q <= '0;
      d_long_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_long_o <= long_fire;
      // The press cycle is cycle 0, so the count is 1 on the first HELD cycle.
      if (state_d == LP_IDLE) begin
        long_cnt_q <= '0;
      end else if (state_q == LP_IDLE) begin
        long_cnt_q <= LW'(1);
      end else if (cnt_inc) begin
        long_cnt_q <= long_cnt_q + LW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LP_IDLE:  if (d_press_o) state_d = LP_HELD;
      LP_HELD: begin
        if (d_release_o)                  state_d = LP_IDLE;
        else if (long_cnt_q == LONG_MAX)  state_d = LP_FIRED;
      end
      LP_FIRED: if (d_release_o) state_d = LP_IDLE;
      default:  state_d = LP_IDLE;
    endcase
  end

  always_comb begin
    long_fire = 1'b0;
    cnt_inc   = 1'b0;
    if (state_q == LP_HELD) begin
      long_fire = !d_release_o && (long_cnt_q == LONG_MAX);
      cnt_inc   = (long_cnt_q != LONG_MAX);
    end
  end

endmodule

// File: tb/tb_ec11b_pin_filter.sv
// tb/tb_ec11b_pin_filter.sv - directed vector bench for ec11b_pin_filter
module tb_ec11b_pin_filter;

  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_AR   = 7'b1000000;
  localparam logic [6:0] P_AF   = 7'b0100000;
  localparam logic [6:0] P_BR   = 7'b0010000;
  localparam logic [6:0] P_BF   = 7'b0001000;
  localparam logic [6:0] P_DP   = 7'b0000100;
  localparam logic [6:0] P_DR   = 7'b0000010;
  localparam logic [6:0] P_DL   = 7'b0000001;

  typedef struct {
    logic [2:0] pins;
    int         n;
    logic [2:0] lvl;
    logic [6:0] pul;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_pin = 1'b1;
  logic b_pin = 1'b1;
  logic d_pin = 1'b1;
  logic a_o, b_o, d_o;
  logic a_rise, a_fall, b_rise, b_fall, d_press, d_release, d_long;

  int checks = 0;
  int errors = 0;
  vec_t tbl [21];

  ec11b_pin_filter #(
    .AB_DEB_CYC(8), .D_DEB_CYC(16), .LONG_CYC(64), .RST_LVL(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .a_pin_i(a_pin), .b_pin_i(b_pin), .d_pin_i(d_pin),
    .a_o(a_o), .b_o(b_o), .d_o(d_o),
    .a_rise_o(a_rise), .a_fall_o(a_fall),
    .b_rise_o(b_rise), .b_fall_o(b_fall),
    .d_press_o(d_press), .d_release_o(d_release), .d_long_o(d_long)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pulses();
    return {a_rise, a_fall, b_rise, b_fall, d_press, d_release, d_long};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run_vec(input string name, input logic [2:0] pins, input int n,
                         input logic [2:0] lvl, input logic [6:0] pul);
    logic [6:0] early;
    early = '0;
    {a_pin, b_pin, d_pin} = pins;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i < n) early |= pulses();
    end
    check({name, " level"}, {4'b0, a_o, b_o, d_o}, {4'b0, lvl});
    check({name, " pulse"}, pulses(), pul);
    if (n > 1) check({name, " quiet"}, early, P_NONE);
  endtask

  initial begin
    tbl[0]  = '{3'b111, 100, 3'b111, P_NONE};
    tbl[1]  = '{3'b011,   9, 3'b111, P_NONE};
    tbl[2]  = '{3'b011,   1, 3'b011, P_AF};
    tbl[3]  = '{3'b011,   1, 3'b011, P_NONE};
    tbl[4]  = '{3'b111,  10, 3'b111, P_AR};
    tbl[5]  = '{3'b101,   7, 3'b111, P_NONE};
    tbl[6]  = '{3'b111,  20, 3'b111, P_NONE};
    tbl[7]  = '{3'b101,   8, 3'b111, P_NONE};
    tbl[8]  = '{3'b111,   2, 3'b101, P_BF};
    tbl[9]  = '{3'b111,   8, 3'b111, P_BR};
    tbl[10] = '{3'b111,  20, 3'b111, P_NONE};
    tbl[11] = '{3'b001,  10, 3'b001, P_AF | P_BF};
    tbl[12] = '{3'b111,  10, 3'b111, P_AR | P_BR};
    tbl[13] = '{3'b110,  18, 3'b110, P_DP};
    tbl[14] = '{3'b110,  64, 3'b110, P_DL};
    tbl[15] = '{3'b110,  18, 3'b110, P_NONE};
    tbl[16] = '{3'b111,  18, 3'b111, P_DR};
    tbl[17] = '{3'b110,  18, 3'b110, P_DP};
    tbl[18] = '{3'b110,  22, 3'b110, P_NONE};
    tbl[19] = '{3'b111,  18, 3'b111, P_DR};
    tbl[20] = '{3'b111,  80, 3'b111, P_NONE};

    repeat (3) @(posedge clk);
    #1;
    check("reset level", {4'b0, a_o, b_o, d_o}, 7'b0000111);
    check("reset pulse", pulses(), P_NONE);
    rst = 1'b0;

    for (int v = 0; v < 21; v++)
      run_vec($sformatf("vec%0d", v), tbl[v].pins, tbl[v].n, tbl[v].lvl, tbl[v].pul);

    // Async reset with A already accepted low: level snaps back without a clock edge.
    run_vec("rst_pre", 3'b011, 10, 3'b011, P_AF);
    #2 rst = 1'b1;
    #1;
    check("rst_async level", {4'b0, a_o, b_o, d_o}, 7'b0000111);
    check("rst_async pulse", pulses(), P_NONE);
    @(posedge clk);
    #1;
    check("rst_hold pulse", pulses(), P_NONE);
    rst = 1'b0;
    run_vec("rst_rel", 3'b011, 10, 3'b011, P_AF);

    // Reset mid-count towards a rise: no rise pulse may follow.
    run_vec("rst_mid_a", 3'b111, 4, 3'b011, P_NONE);
    #2 rst = 1'b1;
    #1;
    check("rst_mid level", {4'b0, a_o, b_o, d_o}, 7'b0000111);
    #1 rst = 1'b0;
    run_vec("rst_mid_b", 3'b111, 20, 3'b111, P_NONE);

    // Reset mid-count towards a fall: acceptance restarts from deassertion.
    run_vec("rst_cnt_a", 3'b011, 5, 3'b111, P_NONE);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    run_vec("rst_cnt_b", 3'b011, 10, 3'b011, P_AF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
